// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks IDLE/FETCH/HOLD/HALTED, drives PC increment/load
// strobes, and keeps a small return-address stack for call/ret.
module fetch_sequencer #(
   parameter int ADDR_W    = 16,
   parameter int RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_cur,
   output logic              pc_load,
   output logic              pc_inc,
   output logic [ADDR_W-1:0] pc_next,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [ADDR_W-1:0] mem_rdata,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] instr,
   input  logic              instr_ready,
   input  logic              redirect,
   input  logic              call,
   input  logic              ret,
   input  logic [ADDR_W-1:0] target,
   input  logic              halt,
   input  logic              resume,
   output logic              busy,
   output logic              ras_err
);

   localparam int PTR_W = $clog2(RAS_DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALTED} state_t;

   state_t            state;
   logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W:0]    ras_cnt;
   logic [PTR_W-1:0]  push_idx;
   logic [PTR_W-1:0]  top_idx;
   logic              ras_empty;
   logic              ras_full;
   logic              handshake;
   logic              do_ret;
   logic              do_call;
   logic              do_redir;

   // Depth is a power of two, so the low count bits wrap cleanly to the top slot.
   assign push_idx  = ras_cnt[PTR_W-1:0];
   assign top_idx   = ras_cnt[PTR_W-1:0] - 1'b1;
   assign ras_empty = (ras_cnt == '0);
   assign ras_full  = (ras_cnt == (PTR_W+1)'(RAS_DEPTH));

   assign handshake = instr_valid & instr_ready;
   assign do_ret    = handshake & ret;
   assign do_call   = handshake & call & ~ret;
   assign do_redir  = handshake & redirect & ~ret & ~call;

   assign pc_inc   = (state == FETCH) & mem_ack;
   assign mem_addr = mem_req ? pc_cur : '0;

   always_comb begin
      // NOTE: defaults first so every path assigns every output; otherwise latches appear.
      pc_load = 1'b0;
      pc_next = '0;
      if (do_ret) begin
         if (!ras_empty) begin
            pc_load = 1'b1;
            pc_next = ras_mem[top_idx];
         end
      end else if (do_call || do_redir) begin
         pc_load = 1'b1;
         pc_next = target;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (rst) begin
         state       <= IDLE;
         mem_req     <= 1'b0;
         instr_valid <= 1'b0;
         busy        <= 1'b0;
         instr       <= '0;
         ras_cnt     <= '0;
         ras_err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state   <= FETCH;
               mem_req <= 1'b1;
               busy    <= 1'b1;
            end
            FETCH: begin
               if (mem_ack) begin
                  state       <= HOLD;
                  instr       <= mem_rdata;
                  mem_req     <= 1'b0;
                  instr_valid <= 1'b1;
               end
            end
            HOLD: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  if (halt) begin
                     state <= HALTED;
                     busy  <= 1'b0;
                     instr <= '0;
                  end else begin
                     state   <= FETCH;
                     mem_req <= 1'b1;
                  end
               end
            end
            HALTED: begin
               if (resume) begin
                  state   <= FETCH;
                  mem_req <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         if (do_call) begin
            if (ras_full) ras_err <= 1'b1;
            else          ras_cnt <= ras_cnt + 1'b1;
         end
         if (do_ret) begin
            if (ras_empty) ras_err <= 1'b1;
            else           ras_cnt <= ras_cnt - 1'b1;
         end
      end
   end

   // NOTE: stack storage has no reset; the count alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (do_call && !ras_full) ras_mem[push_idx] <= pc_cur;
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: models the external PC and a same-cycle-ack memory,
// then walks sequential fetch, back-pressure, call/ret, stack errors, halt/resume and reset.
module tb_fetch_sequencer;

   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [AW-1:0] pc_cur;
   logic          pc_load, pc_inc, mem_req, mem_ack, instr_valid, busy, ras_err;
   logic [AW-1:0] pc_next, mem_addr, mem_rdata, instr;
   logic          instr_ready = 1'b1;
   logic          redirect = 1'b0, call = 1'b0, ret = 1'b0, halt = 1'b0, resume = 1'b0;
   logic [AW-1:0] target = '0;
   logic          ack_en = 1'b1, ack_force = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(.ADDR_W(AW), .RAS_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_load(pc_load), .pc_inc(pc_inc),
      .pc_next(pc_next), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .redirect(redirect), .call(call), .ret(ret),
      .target(target), .halt(halt), .resume(resume), .busy(busy), .ras_err(ras_err)
   );

   // External program counter and a memory that acknowledges in the request cycle.
   always @(posedge clk or posedge rst) begin
      if (rst)          pc_cur <= '0;
      else if (pc_load) pc_cur <= pc_next;
      else if (pc_inc)  pc_cur <= pc_cur + 1'b1;
   end

   assign mem_ack   = (ack_en & mem_req) | ack_force;
   assign mem_rdata = (mem_addr == 16'h0000) ? 16'h1111 :
                      (mem_addr == 16'h0001) ? 16'h2222 : {mem_addr[7:0], 8'hC3};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1 rst = 1'b1;
      #1;
      check("rst_mem_req", 32'(mem_req), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_valid", 32'(instr_valid), 0);
      check("rst_instr", 32'(instr), 0);
      check("rst_ras_err", 32'(ras_err), 0);
      check("rst_pc_load", 32'(pc_load), 0);

      // Sequential fetch with instr_ready held high
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("idle_mem_req", 32'(mem_req), 0);
      tick();
      check("f0_mem_req", 32'(mem_req), 1);
      check("f0_mem_addr", 32'(mem_addr), 32'h0000);
      check("f0_pc_inc", 32'(pc_inc), 1);
      check("f0_busy", 32'(busy), 1);
      tick();
      check("h0_valid", 32'(instr_valid), 1);
      check("h0_instr", 32'(instr), 32'h1111);
      check("h0_pc_inc", 32'(pc_inc), 0);
      check("h0_mem_req", 32'(mem_req), 0);
      tick();
      check("f1_mem_addr", 32'(mem_addr), 32'h0001);
      check("f1_pc_inc", 32'(pc_inc), 1);
      instr_ready = 1'b0;
      tick();
      check("h1_instr", 32'(instr), 32'h2222);

      // Back-pressure: five stalled cycles
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 32'(instr_valid), 1);
         check("bp_instr", 32'(instr), 32'h2222);
         check("bp_mem_req", 32'(mem_req), 0);
         check("bp_pc_inc", 32'(pc_inc), 0);
         tick();
      end

      // Redirect to 0x0010, so the next HOLD sees pc_cur = 0x0011
      instr_ready = 1'b1; redirect = 1'b1; target = 16'h0010;
      #1;
      check("redir_load", 32'(pc_load), 1);
      check("redir_next", 32'(pc_next), 32'h0010);
      tick();
      redirect = 1'b0;
      check("redir_addr", 32'(mem_addr), 32'h0010);
      tick();
      call = 1'b1; target = 16'h0200;
      #1;
      check("call_load", 32'(pc_load), 1);
      check("call_next", 32'(pc_next), 32'h0200);
      check("call_no_inc", 32'(pc_inc), 0);
      tick();
      call = 1'b0;
      check("call_addr", 32'(mem_addr), 32'h0200);
      tick();
      ret = 1'b1;
      #1;
      check("ret_load", 32'(pc_load), 1);
      check("ret_next", 32'(pc_next), 32'h0011);
      tick();
      ret = 1'b0;
      check("ret_addr", 32'(mem_addr), 32'h0011);

      // Five calls into a four-deep stack; pushed 0x0012, 0x0301, 0x0311, 0x0321
      for (int i = 0; i < 5; i++) begin
         tick();
         call = 1'b1; target = 16'h0300 + 16'(i * 16);
         #1;
         check("ovf_load", 32'(pc_load), 1);
         check("ovf_next", 32'(pc_next), 32'(16'h0300 + 16'(i * 16)));
         tick();
         call = 1'b0;
         check("ovf_err", 32'(ras_err), (i == 4) ? 1 : 0);
      end
      check("ovf_jump_addr", 32'(mem_addr), 32'h0340);
      tick();
      ret = 1'b1;
      #1;
      check("lifo_ret1", 32'(pc_next), 32'h0321);
      tick();
      ret = 1'b0;
      tick();
      ret = 1'b1; call = 1'b1; target = 16'h0500;
      #1;
      check("prio_ret", 32'(pc_next), 32'h0311);
      tick();
      ret = 1'b0; call = 1'b0;
      check("err_sticky", 32'(ras_err), 1);

      // Halt together with redirect, then resume
      tick();
      halt = 1'b1; redirect = 1'b1; target = 16'h0040;
      #1;
      check("halt_load", 32'(pc_load), 1);
      check("halt_next", 32'(pc_next), 32'h0040);
      tick();
      halt = 1'b0; redirect = 1'b0;
      check("halted_mem_req", 32'(mem_req), 0);
      check("halted_busy", 32'(busy), 0);
      check("halted_valid", 32'(instr_valid), 0);
      check("halted_instr", 32'(instr), 0);
      check("halted_ras_err", 32'(ras_err), 1);
      tick();
      check("halted_stay", 32'(mem_req), 0);
      resume = 1'b1; ack_en = 1'b0;
      tick();
      resume = 1'b0;
      check("resume_req", 32'(mem_req), 1);
      check("resume_addr", 32'(mem_addr), 32'h0040);
      check("stall_no_inc", 32'(pc_inc), 0);

      // Halt outside the handshake is ignored
      halt = 1'b1;
      tick();
      check("halt_fetch_req", 32'(mem_req), 1);
      check("halt_fetch_addr", 32'(mem_addr), 32'h0040);
      ack_en = 1'b1; instr_ready = 1'b0;
      tick();
      check("halt_hold_instr", 32'(instr), 32'h40C3);
      tick();
      check("halt_hold_valid", 32'(instr_valid), 1);
      halt = 1'b0; instr_ready = 1'b1; ack_en = 1'b0;
      tick();
      check("pre_rst_req", 32'(mem_req), 1);
      check("pre_rst_addr", 32'(mem_addr), 32'h0041);

      // Asynchronous reset mid-fetch, with a late ack during reset and IDLE
      rst = 1'b1; ack_force = 1'b1;
      #1;
      check("arst_mem_req", 32'(mem_req), 0);
      check("arst_ras_err", 32'(ras_err), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_pc_inc", 32'(pc_inc), 0);
      tick();
      rst = 1'b0; ack_en = 1'b1;
      #1;
      check("post_rst_idle", 32'(mem_req), 0);
      check("late_ack_inc", 32'(pc_inc), 0);
      tick();
      ack_force = 1'b0;
      check("post_rst_req", 32'(mem_req), 1);
      check("post_rst_addr", 32'(mem_addr), 32'h0000);

      // Return on an empty stack
      tick();
      ret = 1'b1;
      #1;
      check("unf_no_load", 32'(pc_load), 0);
      check("unf_next", 32'(pc_next), 0);
      tick();
      ret = 1'b0;
      check("unf_err", 32'(ras_err), 1);
      check("unf_seq_addr", 32'(mem_addr), 32'h0001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
